// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, status layout and timer constant for the outbound stride DMA
package dma_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3
  } dma_state_e;
  localparam int ST_STATE_LSB = 0;
  localparam int ST_IRQ       = 3;
  localparam int ST_EMPTY     = 4;
  localparam int ST_PASS_LSB  = 8;
  localparam int ST_REM_LSB   = 16;
  localparam logic [31:0] TIMER_IMMEDIATE = '1;
endpackage

// File: rtl/fwft_sc_fifo.sv
// fwft_sc_fifo: single-clock first-word-fall-through FIFO with synchronous flush
module fwft_sc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
  logic             full, push, pull;
  assign empty   = wp_q == rp_q;
  assign full    = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign push    = wr_en && !full;
  assign pull    = rd_en && !empty;
  assign rd_data = mem_q[rp_q[AW-1:0]];
  // pointers advance on accepted push/pull
  always_comb begin
    wp_d = wp_q + (AW+1)'(push);
    rp_d = rp_q + (AW+1)'(pull);
  end
  // pointer registers; flush empties the FIFO in one cycle
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage, no reset needed since reads are qualified by empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/dma_out_stride.sv
// dma_out_stride: strided, repeating outbound DMA from a memory read port to the crossbar
module dma_out_stride
  import dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int REP_W  = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              config_valid,
  output logic              config_ready,
  input  logic [ADDR_W-1:0] config_start_addr,
  input  logic [ADDR_W-1:0] config_stride,
  input  logic [LEN_W-1:0]  config_length,
  input  logic [REP_W-1:0]  config_repeat,
  input  logic [31:0]       config_timer_init,
  input  logic              config_last,
  input  logic [31:0]       ctimer,
  input  logic              dma_reset,
  output logic [31:0]       status,
  output logic              strobe_complete,
  output logic              irq,
  input  logic              irq_clear,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = LEN_W + REP_W;
  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, start_q, start_d, stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d, word_q, word_d;
  logic [REP_W-1:0]  rep_q, rep_d, pass_q, pass_d;
  logic [TW-1:0]     total_q, total_d, ret_q, ret_d;
  logic [CW-1:0]     cred_q, cred_d, outs_q, outs_d;
  logic              last_q, last_d, cfg_rdy_q, cfg_rdy_d, done_q, done_d;
  logic              strobe_q, strobe_d, irq_q, irq_d;
  logic              abort, issue, pop, wr, tag, fifo_empty;
  logic [DATA_W:0]   fifo_dout;
  assign abort           = dma_reset && (state_q == RUN || state_q == DRAIN);
  assign rd_valid        = state_q == RUN && cred_q < CW'(DEPTH) && !dma_reset;
  assign issue           = rd_valid && rd_ready;
  assign out_valid       = !fifo_empty;
  assign pop             = out_valid && out_ready;
  assign wr              = rd_data_valid && (state_q == RUN || state_q == DRAIN);
  assign tag             = last_q && ret_q == total_q - TW'(1);
  assign out_data        = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign out_last        = !fifo_empty && fifo_dout[DATA_W];
  assign rd_addr         = addr_q;
  assign config_ready    = cfg_rdy_q;
  assign strobe_complete = strobe_q;
  assign irq             = irq_q;
  fwft_sc_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .srst   (srst),
    .flush  (abort),
    .wr_en  (wr),
    .wr_data({tag, rd_data}),
    .rd_en  (pop),
    .rd_data(fifo_dout),
    .empty  (fifo_empty)
  );
  // status word assembly
  always_comb begin
    status = '0;
    status[ST_STATE_LSB +: 3] = state_q;
    status[ST_IRQ]            = irq_q;
    status[ST_EMPTY]          = fifo_empty;
    status[ST_PASS_LSB +: 8]  = 8'(pass_q);
    status[ST_REM_LSB +: 16]  = 16'(total_q - ret_q);
  end
  // job sequencing, address walk and flow-control counters
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_d   = start_q;
    stride_d  = stride_q;
    len_d     = len_q;
    rep_d     = rep_q;
    last_d    = last_q;
    word_d    = word_q;
    pass_d    = pass_q;
    total_d   = total_q;
    ret_d     = ret_q + TW'(wr);
    cred_d    = cred_q + CW'(issue) - CW'(pop);
    outs_d    = outs_q + CW'(issue) - CW'(rd_data_valid);
    cfg_rdy_d = 1'b0;
    done_d    = 1'b0;
    strobe_d  = done_q;
    irq_d     = done_q || (irq_q && !irq_clear);
    case (state_q)
      IDLE: begin
        if (config_valid && !cfg_rdy_q) begin
          if (config_length == '0) begin
            cfg_rdy_d = 1'b1;
          end else if (config_timer_init == TIMER_IMMEDIATE || ctimer == config_timer_init) begin
            state_d  = RUN;
            addr_d   = config_start_addr;
            start_d  = config_start_addr;
            stride_d = config_stride;
            len_d    = config_length;
            rep_d    = config_repeat;
            last_d   = config_last;
            word_d   = '0;
            pass_d   = '0;
            ret_d    = '0;
            total_d  = TW'(config_length) * (TW'(config_repeat) + TW'(1));
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = FLUSH;
          cfg_rdy_d = 1'b1;
          cred_d    = '0;
        end else if (issue) begin
          if (word_q == len_q - LEN_W'(1)) begin
            word_d = '0;
            addr_d = start_q;
            pass_d = pass_q + REP_W'(1);
            if (pass_q == rep_q) state_d = DRAIN;
          end else begin
            word_d = word_q + LEN_W'(1);
            addr_d = addr_q + stride_q;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d   = FLUSH;
          cfg_rdy_d = 1'b1;
          cred_d    = '0;
        end else if (ret_q == total_q && fifo_empty) begin
          state_d   = IDLE;
          cfg_rdy_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      FLUSH: begin
        if (outs_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      start_q   <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      last_q    <= 1'b0;
      word_q    <= '0;
      pass_q    <= '0;
      total_q   <= '0;
      ret_q     <= '0;
      cred_q    <= '0;
      outs_q    <= '0;
      cfg_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      stride_q  <= stride_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      last_q    <= last_d;
      word_q    <= word_d;
      pass_q    <= pass_d;
      total_q   <= total_d;
      ret_q     <= ret_d;
      cred_q    <= cred_d;
      outs_q    <= outs_d;
      cfg_rdy_q <= cfg_rdy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_dma_out_stride.sv
// tb_dma_out_stride: scoreboard bench for the strided outbound DMA
`timescale 1ns/1ps
module tb_dma_out_stride;
  import dma_pkg::*;
  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        config_valid = 1'b0;
  logic        config_ready;
  logic [31:0] config_start_addr = '0;
  logic [31:0] config_stride = '0;
  logic [15:0] config_length = '0;
  logic [7:0]  config_repeat = '0;
  logic [31:0] config_timer_init = '1;
  logic        config_last = 1'b0;
  logic [31:0] ctimer = '0;
  logic        dma_reset = 1'b0;
  logic [31:0] status;
  logic        strobe_complete;
  logic        irq;
  logic        irq_clear = 1'b0;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_data_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0;
  int strb_cnt = 0;
  int iss_cnt = 0;
  int ret_cnt = 0;
  int outv_cnt = 0;
  int lat = 1;
  logic [31:0] exp_addr[$];
  logic [32:0] exp_out[$];
  int          due_q[$];
  logic [31:0] dat_q[$];
  dma_out_stride #(.DEPTH(8)) dut (
    .clk(clk), .srst(srst),
    .config_valid(config_valid), .config_ready(config_ready),
    .config_start_addr(config_start_addr), .config_stride(config_stride),
    .config_length(config_length), .config_repeat(config_repeat),
    .config_timer_init(config_timer_init), .config_last(config_last),
    .ctimer(ctimer), .dma_reset(dma_reset), .status(status),
    .strobe_complete(strobe_complete), .irq(irq), .irq_clear(irq_clear),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  task automatic expect_word(input logic [31:0] a, input logic l);
    exp_addr.push_back(a);
    exp_out.push_back({l, mem_f(a)});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ctimer = ctimer + 1;
  endtask
  task automatic start_job(input logic [31:0] st, input logic [31:0] sd, input logic [15:0] len,
                           input logic [7:0] rep, input logic [31:0] ti, input logic l);
    config_start_addr = st;
    config_stride     = sd;
    config_length     = len;
    config_repeat     = rep;
    config_timer_init = ti;
    config_last       = l;
    config_valid      = 1'b1;
  endtask
  task automatic wait_cfg(input int bound);
    int  c0 = cfg_cnt;
    logic seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (cfg_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    config_valid = 1'b0;
    chk("config_ready_seen", 64'(seen), 64'd1);
  endtask
  task automatic finish_job(input string nm);
    chk({nm, "_strobe"}, 64'(strobe_complete), 64'd1);
    chk({nm, "_irq_set"}, 64'(irq), 64'd1);
    tick();
    chk({nm, "_strobe_pulse"}, 64'(strobe_complete), 64'd0);
    chk({nm, "_irq_sticky"}, 64'(irq), 64'd1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    chk({nm, "_irq_cleared"}, 64'(irq), 64'd0);
    chk({nm, "_out_left"}, 64'(exp_out.size()), 64'd0);
    chk({nm, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
  endtask
  // memory model: returns each accepted read after lat cycles
  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      n++;
      rd_data_valid = 1'b0;
      if (due_q.size() != 0 && due_q[0] <= n) begin
        void'(due_q.pop_front());
        rd_data       = dat_q.pop_front();
        rd_data_valid = 1'b1;
        ret_cnt++;
      end
      if (rd_valid && rd_ready) begin
        due_q.push_back(n + lat);
        dat_q.push_back(mem_f(rd_addr));
      end
    end
  end
  // monitor: compares read addresses and output words against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (config_ready) cfg_cnt++;
      if (strobe_complete) strb_cnt++;
      if (out_valid) outv_cnt++;
      if (rd_valid && rd_ready) begin
        iss_cnt++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_addr: unexpected read of %0h, none expected", rd_addr);
        end else chk("rd_addr", 64'(rd_addr), 64'(exp_addr.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: unexpected word %0h last %0b, none expected", out_data, out_last);
        end else chk("out_word", 64'({out_last, out_data}), 64'(exp_out.pop_front()));
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
  initial begin
    int i0, r0, s0, o0;
    logic reached;
    repeat (3) tick();
    srst = 1'b0;
    chk("rst_config_ready", 64'(config_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'({out_last, out_data}), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_strobe", 64'(strobe_complete), 64'd0);
    chk("rst_status", 64'(status), 64'h10);
    tick();
    // basic job: four words upward
    lat = 1;
    rd_ready = 1'b1;
    out_ready = 1'b1;
    expect_word(32'h100, 1'b0);
    expect_word(32'h101, 1'b0);
    expect_word(32'h102, 1'b0);
    expect_word(32'h103, 1'b1);
    start_job(32'h100, 32'd1, 16'd4, 8'd0, TIMER_IMMEDIATE, 1'b1);
    wait_cfg(60);
    finish_job("basic");
    // negative stride with a repeat pass
    expect_word(32'h10, 1'b0);
    expect_word(32'h0E, 1'b0);
    expect_word(32'h0C, 1'b0);
    expect_word(32'h10, 1'b0);
    expect_word(32'h0E, 1'b0);
    expect_word(32'h0C, 1'b1);
    start_job(32'h10, 32'hFFFF_FFFE, 16'd3, 8'd1, TIMER_IMMEDIATE, 1'b1);
    wait_cfg(80);
    finish_job("neg_stride");
    // zero-length descriptor
    s0 = strb_cnt;
    i0 = iss_cnt;
    start_job(32'h500, 32'd1, 16'd0, 8'd0, TIMER_IMMEDIATE, 1'b1);
    tick();
    chk("len0_config_ready", 64'(config_ready), 64'd1);
    chk("len0_rd_valid", 64'(rd_valid), 64'd0);
    config_valid = 1'b0;
    tick();
    chk("len0_ready_pulse", 64'(config_ready), 64'd0);
    chk("len0_state", 64'(status[2:0]), 64'(IDLE));
    repeat (5) tick();
    chk("len0_no_strobe", 64'(strb_cnt - s0), 64'd0);
    chk("len0_no_issue", 64'(iss_cnt - i0), 64'd0);
    chk("len0_no_irq", 64'(irq), 64'd0);
    // credit limit with stalled crossbar
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) expect_word(32'h200 + 32'(4 * i), 1'b0);
    i0 = iss_cnt;
    start_job(32'h200, 32'd4, 16'd20, 8'd0, TIMER_IMMEDIATE, 1'b0);
    repeat (25) tick();
    chk("credit_issues", 64'(iss_cnt - i0), 64'd8);
    chk("credit_rd_valid", 64'(rd_valid), 64'd0);
    chk("credit_state", 64'(status[2:0]), 64'(RUN));
    out_ready = 1'b1;
    wait_cfg(300);
    finish_job("credit");
    // abort with five reads outstanding
    lat = 10;
    rd_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_addr.push_back(32'h300 + 32'(i));
    i0 = iss_cnt;
    r0 = ret_cnt;
    s0 = strb_cnt;
    o0 = outv_cnt;
    start_job(32'h300, 32'd1, 16'd20, 8'd0, TIMER_IMMEDIATE, 1'b1);
    tick();
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    dma_reset = 1'b1;
    tick();
    dma_reset = 1'b0;
    config_valid = 1'b0;
    chk("abort_config_ready", 64'(config_ready), 64'd1);
    chk("abort_state", 64'(status[2:0]), 64'(FLUSH));
    chk("abort_fifo_empty", 64'(status[ST_EMPTY]), 64'd1);
    chk("abort_issues", 64'(iss_cnt - i0), 64'd5);
    chk("abort_early_returns", 64'(ret_cnt - r0), 64'd0);
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (status[2:0] == IDLE) begin
        reached = 1'b1;
        break;
      end
    end
    chk("flush_idle", 64'(reached), 64'd1);
    chk("flush_returns", 64'(ret_cnt - r0), 64'd5);
    chk("flush_no_out_valid", 64'(outv_cnt - o0), 64'd0);
    chk("flush_no_strobe", 64'(strb_cnt - s0), 64'd0);
    chk("flush_no_irq", 64'(irq), 64'd0);
    chk("flush_addr_left", 64'(exp_addr.size()), 64'd0);
    // delayed start, irq_clear coincident with completion
    lat = 1;
    rd_ready = 1'b1;
    out_ready = 1'b1;
    irq_clear = 1'b1;
    ctimer = 32'd40;
    i0 = iss_cnt;
    expect_word(32'h400, 1'b0);
    expect_word(32'h401, 1'b1);
    start_job(32'h400, 32'd1, 16'd2, 8'd0, 32'd50, 1'b1);
    for (int i = 0; i < 20 && ctimer != 32'd50; i++) tick();
    chk("timer_idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("timer_idle_state", 64'(status[2:0]), 64'(IDLE));
    chk("timer_no_early_issue", 64'(iss_cnt - i0), 64'd0);
    tick();
    chk("timer_first_rd_valid", 64'(rd_valid), 64'd1);
    chk("timer_first_addr", 64'(rd_addr), 64'h400);
    wait_cfg(60);
    irq_clear = 1'b0;
    chk("timer_strobe", 64'(strobe_complete), 64'd1);
    chk("irq_set_wins", 64'(irq), 64'd1);
    tick();
    chk("irq_set_wins_hold", 64'(irq), 64'd1);
    chk("timer_out_left", 64'(exp_out.size()), 64'd0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
